vic_prio_wb: RTL
================

Name: vic_prio_wb

Overview:
Parametrised vectored interrupt controller, successor to the fixed two-channel vic_wb feeding the vm1 CPU's pin_virq and vector read. Adds configurable channel count, per-channel enable mask, per-channel edge/level request mode, a spurious vector, and a readable pending vector. It sits between interrupt sources (keyboard, timers, disk) and the CPU IACK bus cycle, on the CPU bus clock enable.

Parameters:
N, 4, number of interrupt channels (1..16); channel N-1 has highest priority, channel 0 lowest.
SPUR_VEC, 16'o000000, vector returned when IACK finds no eligible request.

Ports:
clk_sys  in  1  system clock; all logic is posedge clk_sys.
reset  in  1  asynchronous active-high reset.
ce  in  1  bus clock enable; every state update except reset is qualified by ce.
ivec  in  16*N  vector table; channel i vector is ivec[16*i+15:16*i].
ireq  in  N  interrupt request per channel.
iedge  in  N  mode per channel: 1 = rising-edge latched, 0 = level.
imask  in  N  enable per channel: 1 = enabled.
iack  out  N  one-ce-period acknowledge pulse to the served source.
pend_o  out  N  current pending vector (before masking).
wb_stb_i  in  1  IACK strobe (iacko & read & bus strobe).
wb_ack_o  out  1  reply to CPU.
wb_dat_o  out  16  vector output; 0 when not replying (OR-bus safe).
wb_irq_o  out  1  registered request to CPU virq.

Behaviour:
- Reset (async): state IDLE, edge latches, sampled ireq history, iack, wb_ack_o, wb_dat_o, wb_irq_o all 0. A reset mid-cycle drops ack/dat at once; no iack is emitted.
- Request sampling, on each ce: req_d <= ireq. Edge channel i: latch[i] set when ireq[i] & ~req_d[i]; cleared when channel i is served. Set wins over clear in the same ce, so no edge is lost. Multiple edges while pending collapse into one.
- pend_o[i] = iedge[i] ? latch[i] : ireq[i]. Level channels have no latch. The source must drop ireq after iack.
- eligible = pend_o & imask. On each ce, wb_irq_o <= |eligible, giving one ce of latency.
- Masking a pending edge channel keeps its latch set. The channel fires again when unmasked.
- Winner: highest index set in eligible, computed combinationally.
- FSM, ce-qualified:
  - IDLE: if wb_stb_i, latch the winner's vector (or SPUR_VEC if eligible==0) into wb_dat_o, set wb_ack_o=1, pulse iack[winner]=1 (none if spurious), clear the winner's edge latch, then go to ACK.
  - ACK: iack <= 0. The vector and ack stay frozen even if higher-priority requests arrive. If ~wb_stb_i, go to IDLE with wb_ack_o=0 and wb_dat_o=0; otherwise go to WAIT.
  - WAIT: hold ack/dat until ~wb_stb_i, then go to IDLE and clear ack/dat.
- Latency: stb seen at ce edge k gives ack, dat and iack valid after edge k. iack deasserts after edge k+1. wb_irq_o reflects the cleared request no earlier than edge k+1.
- iack is one-hot or zero; it is never asserted outside the IDLE→ACK transition.
- Between ce pulses all outputs hold.
- A strobe still high after returning to IDLE cannot occur in the CPU protocol. Behaviour in that case is a new arbitration, which is legal.
- Changing iedge while a channel is pending is undefined for that channel only.

Test Plan:
- Reset mid-ACK: assert reset while wb_ack_o=1 → ack, dat, iack and irq read 0 immediately; after release all are 0 with no spurious iack.
- Priority: N=4, ivec ch3=16'o000060, ch1=16'o000274, iedge=0, imask=4'hF, ireq=4'b1010 → irq=1 one ce later. IACK → dat=16'o000060, iack=4'b1000 for one ce. Drop ireq[3]; second IACK → dat=16'o000274, iack=4'b0010.
- Edge latch and mask: ch2 edge mode, single 1-ce pulse on ireq[2] with imask[2]=0 → pend_o[2]=1, irq=0. Set imask[2]=1 → irq=1. IACK → vector ch2 and pend_o[2]=0. A new edge in the same ce as the IACK leaves pend_o[2]=1.
- Spurious: eligible=0, strobe → dat=SPUR_VEC=0, ack=1, iack=0; strobe low → ack=0, dat=0.
- Late request during ACK: ch0 IACK in progress, raise ireq[3] → dat stays ch0's vector until the strobe drops; the next IACK returns ch3's vector.
- ce gating: ce held low for 10 clocks with a strobe present → no state or output change; the first ce produces ack.

Source files
------------

// File: rtl/vic_prio_wb_if.sv
// CPU-side IACK bus of the vectored interrupt controller: strobe in, ack/vector/irq back.
// The CPU (master) drives wb_stb_i; the controller (slave) answers on the other three.
interface vic_prio_wb_if;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic [15:0] wb_dat_o;
  logic        wb_irq_o;

  modport master (output wb_stb_i, input wb_ack_o, wb_dat_o, wb_irq_o);
  modport slave  (input wb_stb_i, output wb_ack_o, wb_dat_o, wb_irq_o);
endinterface

// File: rtl/vic_prio_wb.sv
// Parametrised vectored interrupt controller: per-channel edge/level request, enable mask,
// fixed priority (highest index wins) and a spurious vector for empty IACK cycles.
module vic_prio_wb #(
  parameter int          N        = 4,
  parameter logic [15:0] SPUR_VEC = 16'o000000
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce,
  input  logic [16*N-1:0] ivec,
  input  logic [N-1:0]    ireq,
  input  logic [N-1:0]    iedge,
  input  logic [N-1:0]    imask,
  output logic [N-1:0]    iack,
  output logic [N-1:0]    pend_o,
  output logic [1:0]      dbg_state,
  vic_prio_wb_if.slave    wb
);

  // Handshake: wb_stb_i is held by the CPU for the whole IACK cycle; wb_ack_o rises one ce
  // after the strobe is seen and stays with a frozen wb_dat_o until the strobe drops, after
  // which both return to 0 on the next ce. wb_dat_o is 0 whenever ack is low (OR-bus).
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK = 2'd1, S_WAIT = 2'd2} state_t;

  state_t         state, state_n;
  logic [N-1:0]   req_d, latch;
  logic [N-1:0]   iack_q, iack_n;
  logic           ack_q, ack_n;
  logic [15:0]    dat_q, dat_n;
  logic           irq_q;
  logic [N-1:0]   clr_n;

  logic [N-1:0]   eligible;
  logic [N-1:0]   win_oh;
  logic [15:0]    win_vec;
  logic           win_valid;

  assign pend_o   = (iedge & latch) | (~iedge & ireq);
  assign eligible = pend_o & imask;

  // Ascending scan so the highest eligible index overwrites the lower ones.
  always_comb begin
    win_oh    = '0;
    win_vec   = 16'd0;
    win_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_vec   = ivec[16*i +: 16];
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    ack_n   = ack_q;
    dat_n   = dat_q;
    iack_n  = '0;
    clr_n   = '0;
    case (state)
      S_IDLE: begin
        if (wb.wb_stb_i) begin
          ack_n   = 1'b1;
          dat_n   = win_valid ? win_vec : SPUR_VEC;
          iack_n  = win_oh;
          clr_n   = win_oh;
          state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (!wb.wb_stb_i) begin
          ack_n   = 1'b0;
          dat_n   = 16'd0;
          state_n = S_IDLE;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb.wb_stb_i) begin
          ack_n   = 1'b0;
          dat_n   = 16'd0;
          state_n = S_IDLE;
        end
      end
      default: begin
        ack_n   = 1'b0;
        dat_n   = 16'd0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      req_d  <= '0;
      latch  <= '0;
      iack_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= 16'd0;
      irq_q  <= 1'b0;
    end else if (ce) begin
      state  <= state_n;
      req_d  <= ireq;
      // A new edge in the serving ce must survive the clear, so set is applied last.
      latch  <= (latch & ~clr_n) | (iedge & ireq & ~req_d);
      iack_q <= iack_n;
      ack_q  <= ack_n;
      dat_q  <= dat_n;
      irq_q  <= |eligible;
    end
  end

  assign iack        = iack_q;
  assign dbg_state   = state;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_irq_o = irq_q;

endmodule
